pwm_cmd_parser: RTL and testbench

//   UART command front-end for the PWM path. Consumes received bytes from the UART receiver,

---
 rtl/pwm_cmd_parser_pkg.sv | 46 ++++
 rtl/pwm_cmd_parser_ascii_digit.sv | 18 +
 rtl/pwm_cmd_parser.sv | 156 +++++++++++++++
 tb/tb_pwm_cmd_parser.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_cmd_parser_pkg.sv
// Shared definitions for the PWM UART command parser.
// Holds the ASCII constants, the parser state encoding, the digit-classification
// payload and the duty arithmetic helper.
package pwm_cmd_parser_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DUTY_W = 7;
    localparam int unsigned POW_W  = 2;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned CNT_W  = 32;

    localparam logic [BYTE_W-1:0] ASCII_CR   = 8'h0D;
    localparam logic [BYTE_W-1:0] ASCII_LF   = 8'h0A;
    localparam logic [BYTE_W-1:0] ASCII_D_UC = 8'h44;
    localparam logic [BYTE_W-1:0] ASCII_D_LC = 8'h64;
    localparam logic [BYTE_W-1:0] ASCII_F_UC = 8'h46;
    localparam logic [BYTE_W-1:0] ASCII_F_LC = 8'h66;
    localparam logic [BYTE_W-1:0] ASCII_ZERO = 8'h30;
    localparam logic [BYTE_W-1:0] ASCII_NINE = 8'h39;
    localparam logic [BYTE_W-1:0] ASCII_3    = 8'h33;

    localparam logic [BYTE_W-1:0] RSP_OK_DEF  = 8'h4B;
    localparam logic [BYTE_W-1:0] RSP_ERR_DEF = 8'h45;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG1,
        ST_ARG2,
        ST_WAIT_CR,
        ST_FLUSH
    } state_e;

    // Classification of one received byte as a command argument digit
    typedef struct packed {
        logic             is_dec;
        logic             is_q;
        logic [DIG_W-1:0] value;
    } digit_t;

    // duty = t*10 + u built from shifts; max 99 fits in 7 bits
    function automatic logic [DUTY_W-1:0] duty_calc(input logic [DIG_W-1:0] t,
                                                     input logic [DIG_W-1:0] u);
        return DUTY_W'({t, 3'b000}) + DUTY_W'({t, 1'b0}) + DUTY_W'(u);
    endfunction

endpackage

// File: rtl/pwm_cmd_parser_ascii_digit.sv
// Combinational ASCII digit classifier.
// Ports: data (received byte) -> digit_c {is_dec '0'..'9', is_q '0'..'3', value}.
module pwm_cmd_parser_ascii_digit
    import pwm_cmd_parser_pkg::*;
(
    input  logic [BYTE_W-1:0] data,
    output digit_t            digit_c
);

    always_comb begin
        digit_c        = '0;
        digit_c.is_dec = (data >= ASCII_ZERO) && (data <= ASCII_NINE);
        digit_c.is_q   = (data >= ASCII_ZERO) && (data <= ASCII_3);
        // '0' is 8'h30, so for any digit byte-'0' equals the low nibble
        digit_c.value  = data[DIG_W-1:0];
    end

endmodule

// File: rtl/pwm_cmd_parser.sv
// UART command front-end for the PWM controller.
// Parses "D<t><u>\r" (duty percent) and "F<a><b>\r" (pow2/pow5 select),
// applies the configuration with a one-cycle cfg_valid pulse and queues a
// one-byte ACK/NAK in a single-entry response register.
// Ports: clk, rst_n | rx_data/rx_valid (from uart_rx) |
//        pow2_cfg/pow5_cfg/duty_cfg/cfg_valid (to pwm_ctrl) |
//        tx_data/tx_valid/tx_ready (to uart_tx) | rsp_drop (lost response pulse).
module pwm_cmd_parser
    import pwm_cmd_parser_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 1_000_000,
    parameter logic [BYTE_W-1:0] RSP_OK         = RSP_OK_DEF,
    parameter logic [BYTE_W-1:0] RSP_ERR        = RSP_ERR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [POW_W-1:0]  pow2_cfg,
    output logic [POW_W-1:0]  pow5_cfg,
    output logic [DUTY_W-1:0] duty_cfg,
    output logic              cfg_valid,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              rsp_drop
);

    state_e            state, state_nxt;
    logic              cmd_f;
    logic [DIG_W-1:0]  arg1, arg2;
    logic [CNT_W-1:0]  tmo_cnt;

    digit_t            dig_c;
    logic              dig_ok_c, is_cr_c, is_d_c, is_f_c, tmo_hit_c;
    logic              apply_c, rsp_gen_c, hs_c;
    logic [BYTE_W-1:0] rsp_byte_c;

    pwm_cmd_parser_ascii_digit u_digit (
        .data    (rx_data),
        .digit_c (dig_c)
    );

    assign is_cr_c  = (rx_data == ASCII_CR);
    assign is_d_c   = (rx_data == ASCII_D_UC) || (rx_data == ASCII_D_LC);
    assign is_f_c   = (rx_data == ASCII_F_UC) || (rx_data == ASCII_F_LC);
    assign dig_ok_c = cmd_f ? dig_c.is_q : dig_c.is_dec;
    assign hs_c     = tx_valid && tx_ready;

    // A byte arriving in the expiry cycle wins over the timeout
    assign tmo_hit_c = (TIMEOUT_CYCLES != 0) && (state != ST_IDLE) && !rx_valid &&
                       (tmo_cnt >= CNT_W'(TIMEOUT_CYCLES));

    // Next-state and per-byte actions
    always_comb begin
        state_nxt  = state;
        apply_c    = 1'b0;
        rsp_gen_c  = 1'b0;
        rsp_byte_c = RSP_ERR;
        if (tmo_hit_c) begin
            state_nxt = ST_IDLE;
        end else if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (is_cr_c || (rx_data == ASCII_LF)) state_nxt = ST_IDLE;
                    else if (is_d_c || is_f_c)            state_nxt = ST_ARG1;
                    else                                  state_nxt = ST_FLUSH;
                end
                ST_ARG1, ST_ARG2: begin
                    if (is_cr_c) begin
                        rsp_gen_c = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (dig_ok_c) begin
                        state_nxt = (state == ST_ARG1) ? ST_ARG2 : ST_WAIT_CR;
                    end else begin
                        state_nxt = ST_FLUSH;
                    end
                end
                ST_WAIT_CR: begin
                    if (is_cr_c) begin
                        apply_c    = 1'b1;
                        rsp_gen_c  = 1'b1;
                        rsp_byte_c = RSP_OK;
                        state_nxt  = ST_IDLE;
                    end else begin
                        state_nxt = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (is_cr_c) begin
                        rsp_gen_c = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, argument capture, timeout counter, config and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_f     <= 1'b0;
            arg1      <= '0;
            arg2      <= '0;
            tmo_cnt   <= '0;
            pow2_cfg  <= '0;
            pow5_cfg  <= '0;
            duty_cfg  <= '0;
            cfg_valid <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            rsp_drop  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cfg_valid <= apply_c;
            rsp_drop  <= 1'b0;

            if (rx_valid || (state == ST_IDLE) || tmo_hit_c) tmo_cnt <= '0;
            else                                             tmo_cnt <= tmo_cnt + CNT_W'(1);

            // Captures are harmless on invalid bytes: the state decides if they are used
            if (rx_valid && !tmo_hit_c) begin
                case (state)
                    ST_IDLE: cmd_f <= is_f_c;
                    ST_ARG1: arg1  <= dig_c.value;
                    ST_ARG2: arg2  <= dig_c.value;
                    default: ;
                endcase
            end

            if (apply_c) begin
                if (cmd_f) begin
                    pow2_cfg <= arg1[POW_W-1:0];
                    pow5_cfg <= arg2[POW_W-1:0];
                end else begin
                    duty_cfg <= duty_calc(arg1, arg2);
                end
            end

            // Single-entry response: a handshake in the same cycle frees the slot
            if (rsp_gen_c) begin
                if (!tx_valid || hs_c) begin
                    tx_data  <= rsp_byte_c;
                    tx_valid <= 1'b1;
                end else begin
                    rsp_drop <= 1'b1;
                end
            end else if (hs_c) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_cmd_parser.sv
// Directed self-checking bench for pwm_cmd_parser.
module tb_pwm_cmd_parser;

    localparam int unsigned TMO = 20;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b0;
    logic [1:0] pow2_cfg, pow5_cfg;
    logic [6:0] duty_cfg;
    logic       cfg_valid, tx_valid, rsp_drop;
    logic [7:0] tx_data;

    int errors   = 0;
    int checks   = 0;
    int cfg_cnt  = 0;
    int drop_cnt = 0;

    pwm_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .pow2_cfg  (pow2_cfg),
        .pow5_cfg  (pow5_cfg),
        .duty_cfg  (duty_cfg),
        .cfg_valid (cfg_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rsp_drop  (rsp_drop)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_valid) cfg_cnt++;
        if (rsp_drop)  drop_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is sampled
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_cmd(input string s, input bit cr);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        if (cr) send_byte(8'h0D);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_rsp(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
        chk({tag, "_data"}, 32'(tx_data), 32'(exp));
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk({tag, "_clr"}, 32'(tx_valid), 32'd0);
    endtask

    task automatic chk_counts(input string tag, input int exp_cfg, input int exp_drop);
        #1;
        chk({tag, "_cfg_cnt"}, 32'(cfg_cnt), 32'(exp_cfg));
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pow2"}, 32'(pow2_cfg), 32'd0);
        chk({tag, "_pow5"}, 32'(pow5_cfg), 32'd0);
        chk({tag, "_duty"}, 32'(duty_cfg), 32'd0);
        chk({tag, "_cfgv"}, 32'(cfg_valid), 32'd0);
        chk({tag, "_txv"}, 32'(tx_valid), 32'd0);
        chk({tag, "_txd"}, 32'(tx_data), 32'd0);
        chk({tag, "_drop"}, 32'(rsp_drop), 32'd0);
    endtask

    string errs[4] = '{"D4x", "F41", "D4", "Q"};

    initial begin
        // Reset values
        idle(3);
        chk_all_zero("rst");
        rst_n = 1'b1;
        idle(2);

        // D42: duty applied, ACK held until tx_ready
        send_cmd("D42", 1);
        chk("d42_cfgv", 32'(cfg_valid), 32'd1);
        chk("d42_duty", 32'(duty_cfg), 32'd42);
        chk("d42_pow2", 32'(pow2_cfg), 32'd0);
        chk("d42_pow5", 32'(pow5_cfg), 32'd0);
        chk("d42_txv", 32'(tx_valid), 32'd1);
        chk("d42_txd", 32'(tx_data), 32'h4B);
        idle(1);
        chk("d42_pulse", 32'(cfg_valid), 32'd0);
        idle(3);
        chk("d42_hold", 32'(tx_data), 32'h4B);
        pop_rsp("d42_rsp", 8'h4B);

        // f31: lowercase letter, pow fields only
        send_cmd("f31", 1);
        chk("f31_cfgv", 32'(cfg_valid), 32'd1);
        chk("f31_pow2", 32'(pow2_cfg), 32'd3);
        chk("f31_pow5", 32'(pow5_cfg), 32'd1);
        chk("f31_duty", 32'(duty_cfg), 32'd42);
        pop_rsp("f31_rsp", 8'h4B);

        // Malformed commands: NAK, nothing applied
        for (int i = 0; i < 4; i++) begin
            send_cmd(errs[i], 1);
            idle(1);
            chk({"err_", errs[i], "_pow2"}, 32'(pow2_cfg), 32'd3);
            chk({"err_", errs[i], "_pow5"}, 32'(pow5_cfg), 32'd1);
            chk({"err_", errs[i], "_duty"}, 32'(duty_cfg), 32'd42);
            pop_rsp({"err_", errs[i], "_rsp"}, 8'h45);
        end
        chk_counts("err", 2, 0);

        // Pause shorter than the timeout keeps the command alive
        send_cmd("D0", 0);
        idle(10);
        send_cmd("5", 1);
        chk("d05_duty", 32'(duty_cfg), 32'd5);
        pop_rsp("d05_rsp", 8'h4B);

        // Timeout discards "D4" silently
        send_cmd("D4", 0);
        idle(40);
        chk("tmo_silent", 32'(tx_valid), 32'd0);
        send_cmd("D07", 1);
        chk("d07_cfgv", 32'(cfg_valid), 32'd1);
        chk("d07_duty", 32'(duty_cfg), 32'd7);
        pop_rsp("d07_rsp", 8'h4B);
        idle(3);
        chk("d07_single", 32'(tx_valid), 32'd0);
        chk_counts("tmo", 4, 0);

        // Pending response blocks a new one: drop pulse, config still applies
        send_cmd("D10", 1);
        chk("d10_txd", 32'(tx_data), 32'h4B);
        send_cmd("D20", 1);
        chk("d20_drop", 32'(rsp_drop), 32'd1);
        chk("d20_cfgv", 32'(cfg_valid), 32'd1);
        chk("d20_duty", 32'(duty_cfg), 32'd20);
        chk("d20_txd", 32'(tx_data), 32'h4B);
        idle(1);
        chk("d20_drop_pulse", 32'(rsp_drop), 32'd0);
        pop_rsp("d20_rsp", 8'h4B);

        send_cmd("Q", 1);
        send_cmd("D33", 1);
        chk("d33_drop", 32'(rsp_drop), 32'd1);
        chk("d33_duty", 32'(duty_cfg), 32'd33);
        chk("d33_txd", 32'(tx_data), 32'h45);
        pop_rsp("d33_rsp", 8'h45);
        chk_counts("drop", 7, 2);

        // Handshake in the same cycle as a new response: replace, no drop
        send_cmd("Q", 1);
        send_cmd("D55", 0);
        tx_ready = 1'b1;
        send_byte(8'h0D);
        tx_ready = 1'b0;
        chk("d55_drop", 32'(rsp_drop), 32'd0);
        chk("d55_txv", 32'(tx_valid), 32'd1);
        chk("d55_txd", 32'(tx_data), 32'h4B);
        chk("d55_duty", 32'(duty_cfg), 32'd55);
        pop_rsp("d55_rsp", 8'h4B);
        chk_counts("repl", 8, 2);

        // Reset mid-command with a response pending
        send_cmd("Q", 1);
        send_cmd("F2", 0);
        rst_n = 1'b0;
        idle(2);
        chk_all_zero("mid_rst");
        rst_n = 1'b1;
        idle(2);
        chk("post_rst_txv", 32'(tx_valid), 32'd0);
        send_cmd("D99", 1);
        chk("d99_cfgv", 32'(cfg_valid), 32'd1);
        chk("d99_duty", 32'(duty_cfg), 32'd99);
        chk("d99_pow2", 32'(pow2_cfg), 32'd0);
        chk("d99_pow5", 32'(pow5_cfg), 32'd0);
        pop_rsp("d99_rsp", 8'h4B);
        chk_counts("end", 9, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
